// File: rtl/pe_conv1d_stream.sv
// rtl/pe_conv1d_stream.sv - streaming 1-D convolution processing element
//
// Samples enter a TAPS-deep sliding window through a valid/ready handshake.
// Every complete window is multiplied by run-time loadable coefficients and
// reduced through two registered stages. The result is either wrapped or
// saturated to OUT_W bits.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   coef_load, coef_in     coefficient load strobe; tap k at [k*COEF_W +: COEF_W]
//   in_valid/in_ready      input sample handshake; in_data sample, in_last end of frame
//   out_valid/out_ready    result handshake; out_data result, out_last end of frame
//   out_sat                result exceeded OUT_W bits
//   short_frame            one-cycle pulse when a frame ended before filling a window
module pe_conv1d_stream #(
    parameter int DATA_W   = 2,
    parameter int COEF_W   = 2,
    parameter int TAPS     = 3,
    parameter int OUT_W    = 8,
    parameter int SAT_MODE = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     coef_load,
    input  logic [TAPS*COEF_W-1:0]   coef_in,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_data,
    output logic                     out_last,
    output logic                     out_sat,
    output logic                     short_frame
);

    localparam int PROD_W = DATA_W + COEF_W;
    localparam int SUM_W  = PROD_W + $clog2(TAPS);
    localparam int CNT_W  = $clog2(TAPS);

    logic [TAPS*COEF_W-1:0] coef_q;
    logic [DATA_W-1:0]      win [TAPS];
    logic [CNT_W-1:0]       cnt;

    // Window stage: a complete window sitting in win[] waiting for products
    logic                   s0_valid;
    logic                   s0_last;

    logic [PROD_W-1:0]      s1_prod [TAPS];
    logic                   s1_valid;
    logic                   s1_last;

    logic                   advance;
    logic                   accept;
    logic                   full;

    logic [SUM_W-1:0]       sum;
    logic [OUT_W-1:0]       res_data;
    logic                   res_ovf;

    // The whole pipeline freezes while a result waits on the consumer
    assign advance  = !(out_valid && !out_ready);
    assign in_ready = advance && !coef_load && !rst;
    assign accept   = in_valid && in_ready;
    assign full     = (cnt == CNT_W'(TAPS - 1));

    always_comb begin
        sum = '0;
        for (int k = 0; k < TAPS; k++) begin
            sum = sum + SUM_W'(s1_prod[k]);
        end
    end

    generate
        if (OUT_W >= SUM_W) begin : g_wide
            assign res_data = OUT_W'(sum);
            assign res_ovf  = 1'b0;
        end else begin : g_narrow
            assign res_ovf  = |sum[SUM_W-1:OUT_W];
            assign res_data = (SAT_MODE != 0 && res_ovf) ? {OUT_W{1'b1}} : sum[OUT_W-1:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            coef_q      <= '0;
            cnt         <= '0;
            s0_valid    <= 1'b0;
            s0_last     <= 1'b0;
            s1_valid    <= 1'b0;
            s1_last     <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_last    <= 1'b0;
            out_sat     <= 1'b0;
            short_frame <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                win[k]     <= '0;
                s1_prod[k] <= '0;
            end
        end else begin
            if (coef_load) begin
                coef_q <= coef_in;
            end

            short_frame <= accept && in_last && !full;

            // win[0] holds the oldest sample and pairs with c[0]
            if (accept) begin
                for (int k = 0; k < TAPS - 1; k++) begin
                    win[k] <= win[k+1];
                end
                win[TAPS-1] <= in_data;
                if (in_last) begin
                    cnt <= '0;
                end else if (!full) begin
                    cnt <= cnt + CNT_W'(1);
                end
            end

            if (advance) begin
                s0_valid <= accept && full;
                s0_last  <= in_last;

                s1_valid <= s0_valid;
                s1_last  <= s0_last;
                for (int k = 0; k < TAPS; k++) begin
                    s1_prod[k] <= PROD_W'(win[k]) * PROD_W'(coef_q[k*COEF_W +: COEF_W]);
                end

                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_data <= res_data;
                    out_last <= s1_last;
                    out_sat  <= res_ovf;
                end
            end
        end
    end

endmodule

// File: tb/tb_pe_conv1d_stream.sv
// tb/tb_pe_conv1d_stream.sv - directed self-checking bench for pe_conv1d_stream
module tb_pe_conv1d_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic       coef_load;
    logic [5:0] coef_in;
    logic       in_valid;
    logic [1:0] in_data;
    logic       in_last;
    logic       out_ready;

    logic       in_ready, out_valid, out_last, out_sat, short_frame;
    logic [7:0] out_data;
    logic       s4_in_ready, s4_valid, s4_last, s4_sat, s4_short;
    logic [3:0] s4_data;
    logic       w4_in_ready, w4_valid, w4_last, w4_sat, w4_short;
    logic [3:0] w4_data;

    always #5 clk = ~clk;

    pe_conv1d_stream u_dut (
        .clk(clk), .rst(rst), .coef_load(coef_load), .coef_in(coef_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_sat(out_sat), .short_frame(short_frame)
    );

    pe_conv1d_stream #(.OUT_W(4), .SAT_MODE(1)) u_sat4 (
        .clk(clk), .rst(rst), .coef_load(coef_load), .coef_in(coef_in),
        .in_valid(in_valid), .in_ready(s4_in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(s4_valid), .out_ready(out_ready), .out_data(s4_data),
        .out_last(s4_last), .out_sat(s4_sat), .short_frame(s4_short)
    );

    pe_conv1d_stream #(.OUT_W(4), .SAT_MODE(0)) u_wrap4 (
        .clk(clk), .rst(rst), .coef_load(coef_load), .coef_in(coef_in),
        .in_valid(in_valid), .in_ready(w4_in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(w4_valid), .out_ready(out_ready), .out_data(w4_data),
        .out_last(w4_last), .out_sat(w4_sat), .short_frame(w4_short)
    );

    typedef struct {
        logic [5:0] coef;
        int         n;
        int         s[5];
        int         ne;
        int         e[3];
    } vec_t;

    vec_t vecs[4];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int sf_cnt   = 0;
    int q_data[$], q_last[$], q_sat[$], q_cyc[$];
    int q_s4d[$], q_s4s[$], q_w4d[$], q_w4s[$];
    int acc_edge[5];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            q_data.push_back(int'(out_data));
            q_last.push_back(int'(out_last));
            q_sat.push_back(int'(out_sat));
            q_cyc.push_back(cyc);
        end
        if (s4_valid && out_ready) begin
            q_s4d.push_back(int'(s4_data));
            q_s4s.push_back(int'(s4_sat));
        end
        if (w4_valid && out_ready) begin
            q_w4d.push_back(int'(w4_data));
            q_w4s.push_back(int'(w4_sat));
        end
        if (short_frame) sf_cnt++;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_q();
        q_data.delete(); q_last.delete(); q_sat.delete(); q_cyc.delete();
        q_s4d.delete(); q_s4s.delete(); q_w4d.delete(); q_w4s.delete();
        sf_cnt = 0;
    endtask

    function automatic int qget(input int q[$], input int j);
        return (j < q.size()) ? q[j] : -1;
    endfunction

    task automatic load_coef(input logic [5:0] c);
        coef_in   = c;
        coef_load = 1'b1;
        in_valid  = 1'b1;
        in_data   = 2'd3;
        in_last   = 1'b0;
        @(negedge clk);
        check("in_ready_during_coef_load", int'(in_ready), 0);
        @(posedge clk); #1;
        coef_load = 1'b0;
        in_valid  = 1'b0;
    endtask

    task automatic send(input int d, input logic l, output int edge_no);
        int t;
        in_valid = 1'b1;
        in_data  = 2'(d);
        in_last  = l;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            t++;
            @(negedge clk);
        end
        if (t >= 50) check("send_timeout", 1, 0);
        edge_no = cyc + 1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_out(input int n);
        int t;
        t = 0;
        while (q_data.size() < n && t < 40) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 40) check("output_timeout", q_data.size(), n);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input vec_t v, input int idx);
        int e;
        load_coef(v.coef);
        clear_q();
        for (int j = 0; j < v.n; j++) begin
            send(v.s[j], j == v.n - 1, e);
            acc_edge[j] = e;
        end
        wait_out(v.ne);
        check($sformatf("v%0d_count", idx), q_data.size(), v.ne);
        for (int j = 0; j < v.ne; j++) begin
            check($sformatf("v%0d_data%0d", idx, j), qget(q_data, j), v.e[j]);
            check($sformatf("v%0d_last%0d", idx, j), qget(q_last, j), (j == v.ne - 1) ? 1 : 0);
            check($sformatf("v%0d_sat%0d", idx, j), qget(q_sat, j), 0);
        end
    endtask

    initial begin
        int e;

        vecs[0].coef = 6'b111001; vecs[0].n = 5; vecs[0].s = '{1, 2, 3, 0, 1};
        vecs[0].ne = 3; vecs[0].e = '{14, 8, 6};
        vecs[1].coef = 6'b111111; vecs[1].n = 3; vecs[1].s = '{3, 3, 3, 0, 0};
        vecs[1].ne = 1; vecs[1].e = '{27, 0, 0};
        vecs[2].coef = 6'b010000; vecs[2].n = 3; vecs[2].s = '{1, 2, 3, 0, 0};
        vecs[2].ne = 1; vecs[2].e = '{3, 0, 0};
        vecs[3].coef = 6'b000110; vecs[3].n = 4; vecs[3].s = '{3, 0, 2, 1, 0};
        vecs[3].ne = 2; vecs[3].e = '{6, 2, 0};

        rst = 1'b1; coef_load = 1'b0; coef_in = '0; in_valid = 1'b0;
        in_data = '0; in_last = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", int'(in_ready), 0);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_data", int'(out_data), 0);
        check("reset_short_frame", int'(short_frame), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            run_frame(vecs[i], i);
            if (i == 0) check("latency", qget(q_cyc, 0) - acc_edge[2], 2);
            if (i == 1) begin
                check("sat4_data", qget(q_s4d, 0), 15);
                check("sat4_flag", qget(q_s4s, 0), 1);
                check("wrap4_data", qget(q_w4d, 0), 11);
                check("wrap4_flag", qget(q_w4s, 0), 1);
            end
        end

        // Backpressure: first result held for 5 cycles
        load_coef(6'b111001);
        clear_q();
        out_ready = 1'b0;
        send(1, 1'b0, e); send(2, 1'b0, e); send(3, 1'b0, e);
        send(0, 1'b0, e); send(1, 1'b1, e);
        for (int t = 0; t < 20 && !out_valid; t++) begin
            @(posedge clk); #1;
        end
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            check("stall_in_ready", int'(in_ready), 0);
            check("stall_out_valid", int'(out_valid), 1);
            check("stall_out_data", int'(out_data), 14);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_out(3);
        check("bp_count", q_data.size(), 3);
        check("bp_data0", qget(q_data, 0), 14);
        check("bp_data1", qget(q_data, 1), 8);
        check("bp_data2", qget(q_data, 2), 6);
        check("bp_last2", qget(q_last, 2), 1);

        // Short frame followed by a normal frame
        load_coef(6'b111001);
        clear_q();
        send(2, 1'b0, e); send(1, 1'b1, e);
        repeat (6) @(posedge clk);
        #1;
        check("short_no_output", q_data.size(), 0);
        check("short_pulse_count", sf_cnt, 1);
        send(1, 1'b0, e); send(1, 1'b0, e); send(1, 1'b1, e);
        wait_out(1);
        check("after_short_count", q_data.size(), 1);
        check("after_short_data", qget(q_data, 0), 6);
        check("after_short_last", qget(q_last, 0), 1);

        // Mid-frame reset
        load_coef(6'b111001);
        clear_q();
        send(3, 1'b0, e); send(3, 1'b0, e);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_out_data", int'(out_data), 0);
        check("midrst_out_last", int'(out_last), 0);
        check("midrst_out_sat", int'(out_sat), 0);
        check("midrst_short", int'(short_frame), 0);
        send(1, 1'b0, e); send(1, 1'b0, e); send(1, 1'b1, e);
        wait_out(1);
        check("coef_cleared_count", q_data.size(), 1);
        check("coef_cleared_data", qget(q_data, 0), 0);
        load_coef(6'b111001);
        clear_q();
        send(1, 1'b0, e); send(2, 1'b0, e); send(3, 1'b1, e);
        wait_out(1);
        check("post_rst_count", q_data.size(), 1);
        check("post_rst_data", qget(q_data, 0), 14);
        check("post_rst_last", qget(q_last, 0), 1);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
